// File: rtl/coin_input_conditioner.sv
// Coin-slot and cancel-button front end: synchronise, debounce, pulse moeda/desiste, count coins.
// Define COIN_JAM_DETECT_EN to build the jam detector (JAM state, width counter, jam output).
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_raw,
  input  logic       cancel_raw,
  output logic       moeda,
  output logic       desiste,
  output logic       jam,
  output logic [7:0] coin_count
);

  typedef enum logic [1:0] {IDLE, COIN_IN, JAM} CoinState;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_coinSync1, r_coinSync2, r_coinDeb;
  logic       r_cancelSync1, r_cancelSync2, r_cancelDeb;
  logic [7:0] r_coinDbCnt, r_cancelDbCnt;
  logic       w_coinLevel, w_cancelLevel, w_cancelRise;

  CoinState   r_state, w_stateNext;
  logic       r_moeda, r_desiste, r_pending;
  logic       w_moedaNext, w_desisteNext, w_pendingNext;
  logic [7:0] r_coinCount, w_countNext;

`ifdef COIN_JAM_DETECT_EN
  localparam logic [15:0] JAM_LAST = 16'(JAM_CYCLES - 1);
  logic [15:0] r_width, w_widthNext;
`endif

  // The FSM reacts to the debounced value the cycle it is decided, so a flip is seen one edge early.
  assign w_coinLevel   = (r_coinSync2 != r_coinDeb && r_coinDbCnt == DB_LAST) ? r_coinSync2 : r_coinDeb;
  assign w_cancelLevel = (r_cancelSync2 != r_cancelDeb && r_cancelDbCnt == DB_LAST) ? r_cancelSync2 : r_cancelDeb;
  assign w_cancelRise  = w_cancelLevel & ~r_cancelDeb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_coinSync1   <= 1'b0;
      r_coinSync2   <= 1'b0;
      r_coinDeb     <= 1'b0;
      r_coinDbCnt   <= 8'd0;
      r_cancelSync1 <= 1'b0;
      r_cancelSync2 <= 1'b0;
      r_cancelDeb   <= 1'b0;
      r_cancelDbCnt <= 8'd0;
    end else begin
      r_coinSync1   <= coin_raw;
      r_coinSync2   <= r_coinSync1;
      r_coinDeb     <= w_coinLevel;
      r_coinDbCnt   <= (r_coinSync2 == r_coinDeb || r_coinDbCnt == DB_LAST) ? 8'd0 : r_coinDbCnt + 8'd1;
      r_cancelSync1 <= cancel_raw;
      r_cancelSync2 <= r_cancelSync1;
      r_cancelDeb   <= w_cancelLevel;
      r_cancelDbCnt <= (r_cancelSync2 == r_cancelDeb || r_cancelDbCnt == DB_LAST) ? 8'd0 : r_cancelDbCnt + 8'd1;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_moedaNext   = 1'b0;
    w_desisteNext = r_pending;
    w_pendingNext = 1'b0;
    w_countNext   = r_coinCount;
`ifdef COIN_JAM_DETECT_EN
    w_widthNext   = r_width;
`endif
    case (r_state)
      IDLE: begin
        if (w_cancelRise) w_desisteNext = 1'b1;
        if (w_coinLevel) begin
          w_stateNext = COIN_IN;
`ifdef COIN_JAM_DETECT_EN
          w_widthNext = 16'd0;
`endif
        end
      end
      COIN_IN: begin
        // A cancel arriving on the exit cycle is deferred one cycle behind moeda.
        if (!w_coinLevel) begin
          w_stateNext   = IDLE;
          w_moedaNext   = 1'b1;
          w_countNext   = r_coinCount + 8'd1;
          w_pendingNext = w_cancelRise;
        end
`ifdef COIN_JAM_DETECT_EN
        else if (r_width == JAM_LAST) begin
          w_stateNext = JAM;
        end else begin
          w_widthNext = r_width + 16'd1;
        end
`endif
      end
`ifdef COIN_JAM_DETECT_EN
      JAM: begin
        if (!w_coinLevel) w_stateNext = IDLE;
      end
`endif
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_moeda     <= 1'b0;
      r_desiste   <= 1'b0;
      r_pending   <= 1'b0;
      r_coinCount <= 8'd0;
`ifdef COIN_JAM_DETECT_EN
      r_width     <= 16'd0;
`endif
    end else begin
      r_state     <= w_stateNext;
      r_moeda     <= w_moedaNext;
      r_desiste   <= w_desisteNext;
      r_pending   <= w_pendingNext;
      r_coinCount <= w_countNext;
`ifdef COIN_JAM_DETECT_EN
      r_width     <= w_widthNext;
`endif
    end
  end

  assign moeda      = r_moeda;
  assign desiste    = r_desiste;
  assign coin_count = r_coinCount;

`ifdef COIN_JAM_DETECT_EN
  assign jam = (r_state == JAM) && w_coinLevel;
`else
  assign jam = 1'b0;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner: directed scenarios plus random raw inputs,
// compared every cycle against an edge-indexed model of debouncing and coin/cancel rules.
module tb_coin_input_conditioner;

  localparam int D    = 4;
  localparam int J    = 64;
  localparam int MAXE = 8192;
`ifdef COIN_JAM_DETECT_EN
  localparam bit JAM_EN = 1'b1;
`else
  localparam bit JAM_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_raw = 1'b0;
  logic       cancel_raw = 1'b0;
  logic       moeda, desiste, jam;
  logic [7:0] coin_count;

  int checks = 0;
  int errors = 0;

  // Model state: raw[ch][e] is the input present before rising edge e (ch 0 = coin, 1 = cancel),
  // deb[ch][e] is the debounced level the design acts on during the cycle after edge e.
  int         e;
  bit         raw[2][MAXE];
  bit         deb[2][MAXE];
  int         riseT;
  bit         pendNext;
  logic [7:0] expCount;
  bit         expM, expD, expJ;
  logic [7:0] startCount;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
    .clock(clock), .reset(reset), .coin_raw(coin_raw), .cancel_raw(cancel_raw),
    .moeda(moeda), .desiste(desiste), .jam(jam), .coin_count(coin_count)
  );

  always #5 clock = ~clock;

  function automatic bit rawAt(int ch, int i);
    return (i < 1) ? 1'b0 : raw[ch][i];
  endfunction

  function automatic bit debAt(int ch, int i);
    return (i < 1) ? 1'b0 : deb[ch][i];
  endfunction

  task automatic resetModel();
    e = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < MAXE; i++) begin
        raw[ch][i] = 1'b0;
        deb[ch][i] = 1'b0;
      end
    riseT    = -100000;
    pendNext = 1'b0;
    expCount = 8'd0;
  endtask

  // A new level is adopted once the raw input has held it for D consecutive cycles.
  task automatic modelStep();
    bit v, same, fallC, riseC, riseK, jammedExit;
    for (int ch = 0; ch < 2; ch++) begin
      v    = rawAt(ch, e - 1);
      same = 1'b1;
      for (int j = e - D; j <= e - 1; j++)
        if (rawAt(ch, j) != v) same = 1'b0;
      deb[ch][e] = (same && v != debAt(ch, e - 1)) ? v : debAt(ch, e - 1);
    end
    riseC = debAt(0, e - 1) && !debAt(0, e - 2);
    fallC = !debAt(0, e - 1) && debAt(0, e - 2);
    riseK = debAt(1, e - 1) && !debAt(1, e - 2);
    expM       = 1'b0;
    expD       = pendNext;
    pendNext   = 1'b0;
    jammedExit = 1'b0;
    if (riseC) riseT = e - 1;
    if (fallC) begin
      jammedExit = JAM_EN && ((e - 1 - riseT) >= J + 1);
      if (!jammedExit) begin
        expM     = 1'b1;
        expCount = expCount + 8'd1;
      end
    end
    if (riseK) begin
      if (!debAt(0, e - 2)) expD = 1'b1;
      else if (fallC && !jammedExit) pendNext = 1'b1;
    end
    expJ = JAM_EN && deb[0][e] && debAt(0, e - 1) && (e >= riseT + 1 + J);
  endtask

  task automatic checkOutput(input string tag, input bit m, input bit d, input bit j, input logic [7:0] c);
    checks++;
    assert (moeda === m) else begin
      errors++;
      $error("[TB] FAIL %s moeda observed %b expected %b edge %0d", tag, moeda, m, e);
    end
    checks++;
    assert (desiste === d) else begin
      errors++;
      $error("[TB] FAIL %s desiste observed %b expected %b edge %0d", tag, desiste, d, e);
    end
    checks++;
    assert (jam === j) else begin
      errors++;
      $error("[TB] FAIL %s jam observed %b expected %b edge %0d", tag, jam, j, e);
    end
    checks++;
    assert (coin_count === c) else begin
      errors++;
      $error("[TB] FAIL %s coin_count observed %0d expected %0d edge %0d", tag, coin_count, c, e);
    end
  endtask

  task automatic checkCount(input string tag, input logic [7:0] c);
    checks++;
    assert (coin_count === c) else begin
      errors++;
      $error("[TB] FAIL %s coin_count observed %0d expected %0d", tag, coin_count, c);
    end
  endtask

  task automatic applyStimulus(input bit c, input bit k, input int n);
    for (int i = 0; i < n; i++) begin
      coin_raw   = c;
      cancel_raw = k;
      @(posedge clock);
      e++;
      if (e >= MAXE) begin
        $display("[TB] FAIL modelRange edge %0d exceeds %0d", e, MAXE);
        $fatal(1, "[TB] model history exhausted");
      end
      raw[0][e] = c;
      raw[1][e] = k;
      modelStep();
      #1 checkOutput("step", expM, expD, expJ, expCount);
    end
  endtask

  task automatic applyReset(input int n, input bit coinDuring);
    #1 reset = 1'b0;
    coin_raw   = coinDuring;
    cancel_raw = 1'b0;
    #1 checkOutput("resetAsync", 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (n) begin
      @(posedge clock);
      #1 checkOutput("resetHold", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    resetModel();
  endtask

  initial begin
    $display("[TB] coin_input_conditioner bench, jam detect %0d", JAM_EN);
    applyReset(3, 1'b0);

    // Clean coin
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 15);
    checkCount("cleanCount", 8'd1);

    // Bounce shorter than the debounce window
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 12);
    checkCount("bounceCount", 8'd1);

    // Long coin then a clean one
    applyStimulus(1'b1, 1'b0, 100);
    applyStimulus(1'b0, 1'b0, 15);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 15);
    checkCount("jamCount", JAM_EN ? 8'd2 : 8'd3);

    // Cancel while idle, then cancel during a coin
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 15);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 15);

    // Coin fall and cancel rise on the same edge
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 15);

    // 256 coins wrap the counter
    startCount = expCount;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, D + 2);
      applyStimulus(1'b0, 1'b0, D + 2);
    end
    applyStimulus(1'b0, 1'b0, 5);
    checkCount("wrapCount", startCount);

    // Random raw activity on both inputs, including bounces
    for (int i = 0; i < 40; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    applyStimulus(1'b0, 1'b0, 15);

    // Reset in the middle of a coin after three credits
    applyReset(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 8);
    end
    checkCount("preResetCount", 8'd3);
    applyStimulus(1'b1, 1'b0, 10);
    applyReset(4, 1'b0);
    applyStimulus(1'b0, 1'b0, 20);
    checkCount("afterResetCount", 8'd0);

    // Coin held through reset release is a fresh insertion
    applyStimulus(1'b1, 1'b0, 3);
    applyReset(3, 1'b1);
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 15);
    checkCount("freshCount", 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
